// File: rtl/mfcc_dct_if.sv
// mfcc_dct_if: start/config, mel and coefficient read ports, and MFCC write port of the DCT stage
interface mfcc_dct_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int COF_ADDR_WIDTH = 12
);
    logic                      dct_start;
    logic [5:0]                mel_num;
    logic [5:0]                cep_num;
    logic [ADDR_WIDTH-1:0]     mel_mem_read_addr;
    logic [DATA_WIDTH-1:0]     mel_data_in;
    logic [COF_ADDR_WIDTH-1:0] dct_cof_read_addr;
    logic [DATA_WIDTH-1:0]     dct_cof_in;
    logic [ADDR_WIDTH-1:0]     mfcc_write_addr;
    logic [DATA_WIDTH-1:0]     mfcc_data_out;
    logic                      write_mfcc_en;
    logic                      dct_busy;
    logic                      dct_done;
    modport master (
        output dct_start, mel_num, cep_num, mel_data_in, dct_cof_in,
        input  mel_mem_read_addr, dct_cof_read_addr, mfcc_write_addr, mfcc_data_out,
               write_mfcc_en, dct_busy, dct_done
    );
    modport slave (
        input  dct_start, mel_num, cep_num, mel_data_in, dct_cof_in,
        output mel_mem_read_addr, dct_cof_read_addr, mfcc_write_addr, mfcc_data_out,
               write_mfcc_en, dct_busy, dct_done
    );
endinterface

// File: rtl/mfcc_dct.sv
// mfcc_dct: cepstral DCT of log-mel energies, one multiply-accumulate term at a time on clocked fp32 units
module mul_fp_clk #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] pipe [LAT-1];
    // Truncating fp32 multiply; subnormal inputs and underflow flush to signed zero
    function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] z);
        logic [47:0]       p;
        logic signed [9:0] e;
        p = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, z[22:0]};
        e = $signed({2'b0, x[30:23]}) + $signed({2'b0, z[30:23]}) - 10'sd127 + $signed({9'd0, p[47]});
        if (x[30:23] == 8'd0 || z[30:23] == 8'd0 || e <= 10'sd0) return {x[31] ^ z[31], 31'd0};
        if (e >= 10'sd255) return {x[31] ^ z[31], 8'hff, 23'd0};
        return {x[31] ^ z[31], e[7:0], p[47] ? p[46:24] : p[45:23]};
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT-1; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= fp_mul(a, b);
            for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign y = pipe[LAT-2];
endmodule

module add_fp_clk #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic [31:0] pipe [LAT-1];
    // Truncating fp32 add with three guard bits; subnormals treated as zero
    function automatic logic [31:0] fp_add(input logic [31:0] p, input logic [31:0] q);
        logic [31:0]       x;
        logic [31:0]       z;
        logic [7:0]        d;
        logic [26:0]       mz;
        logic [27:0]       t;
        logic signed [9:0] e;
        x = (p[30:0] >= q[30:0]) ? p : q;
        z = (p[30:0] >= q[30:0]) ? q : p;
        if (x[30:23] == 8'd0) return 32'd0;
        if (z[30:23] == 8'd0) return x;
        d  = x[30:23] - z[30:23];
        mz = (d > 8'd26) ? 27'd0 : ({1'b1, z[22:0], 3'b0} >> d);
        t  = (x[31] == z[31]) ? {2'b01, x[22:0], 3'b0} + {1'b0, mz} : {2'b01, x[22:0], 3'b0} - {1'b0, mz};
        e  = $signed({2'b0, x[30:23]});
        if (t == 28'd0) return 32'd0;
        if (t[27]) begin
            t = t >> 1;
            e = e + 10'sd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!t[26]) begin
                t = t << 1;
                e = e - 10'sd1;
            end
        end
        if (e >= 10'sd255) return {x[31], 8'hff, 23'd0};
        if (e <= 10'sd0) return 32'd0;
        return {x[31], e[7:0], t[25:3]};
    endfunction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT-1; i++) pipe[i] <= '0;
        end else if (en) begin
            pipe[0] <= fp_add(a, b);
            for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign y = pipe[LAT-2];
endmodule

module mfcc_dct #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int COF_ADDR_WIDTH = 12,
    parameter int MUL_LAT        = 2,
    parameter int ADD_LAT        = 2
) (
    input logic       clk,
    input logic       rst_n,
    mfcc_dct_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, MEM, MUL, ADD, WRITE, DONE} state_t;
    state_t                    state, nxt;
    logic [3:0]                cnt;
    logic [5:0]                mel_n, cep_n, m, k;
    logic [COF_ADDR_WIDTH-1:0] cof_addr;
    logic [DATA_WIDTH-1:0]     acc, prod, sum, wr_data;
    logic [ADDR_WIDTH-1:0]     wr_addr;
    logic                      mul_en, add_en, mul_last, add_last, last_term;
    assign mul_last  = {28'd0, cnt} == MUL_LAT - 1;
    assign add_last  = {28'd0, cnt} == ADD_LAT - 1;
    assign last_term = m == mel_n - 6'd1;
    always_comb begin
        nxt    = state;
        mul_en = 1'b0;
        add_en = 1'b0;
        case (state)
            IDLE:    if (bus.dct_start) nxt = (bus.mel_num == 6'd0 || bus.cep_num == 6'd0) ? DONE : ADDR;
            ADDR:    nxt = MEM;
            MEM:     nxt = MUL;
            MUL: begin
                mul_en = 1'b1;
                nxt    = mul_last ? ADD : MUL;
            end
            ADD: begin
                add_en = 1'b1;
                nxt    = add_last ? (last_term ? WRITE : ADDR) : ADD;
            end
            WRITE:   nxt = (k == cep_n - 6'd1) ? DONE : ADDR;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            mel_n    <= '0;
            cep_n    <= '0;
            m        <= '0;
            k        <= '0;
            cof_addr <= '0;
            acc      <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt == state && (state == MUL || state == ADD)) ? cnt + 4'd1 : 4'd0;
            if (state == IDLE && bus.dct_start) begin
                mel_n    <= bus.mel_num;
                cep_n    <= bus.cep_num;
                m        <= '0;
                k        <= '0;
                cof_addr <= '0;
                acc      <= '0;
            end
            // cof_addr runs straight through rows, so it tracks k*M+m without a multiplier
            if (state == ADD && add_last) begin
                acc      <= sum;
                cof_addr <= cof_addr + COF_ADDR_WIDTH'(1);
                if (last_term) begin
                    wr_addr <= ADDR_WIDTH'(k);
                    wr_data <= sum;
                end else begin
                    m <= m + 6'd1;
                end
            end
            if (state == WRITE) begin
                acc <= '0;
                m   <= '0;
                if (k != cep_n - 6'd1) k <= k + 6'd1;
            end
        end
    end
    mul_fp_clk #(.LAT(MUL_LAT)) u_mul (
        .clk(clk), .rst_n(rst_n), .en(mul_en), .a(bus.mel_data_in), .b(bus.dct_cof_in), .y(prod)
    );
    add_fp_clk #(.LAT(ADD_LAT)) u_add (
        .clk(clk), .rst_n(rst_n), .en(add_en), .a(prod), .b(acc), .y(sum)
    );
    assign bus.mel_mem_read_addr = ADDR_WIDTH'(m);
    assign bus.dct_cof_read_addr = cof_addr;
    assign bus.mfcc_write_addr   = wr_addr;
    assign bus.mfcc_data_out     = wr_data;
    assign bus.write_mfcc_en     = state == WRITE;
    assign bus.dct_done          = state == DONE;
    assign bus.dct_busy          = state != IDLE && state != DONE;
endmodule

// File: tb/tb_mfcc_dct.sv
// tb_mfcc_dct: directed frames with a cycle-stamped scoreboard of writes, done pulses and address/busy probes
module tb_mfcc_dct;
    typedef struct {int cyc; logic [31:0] addr; logic [31:0] data;} write_t;
    typedef struct {int cyc; int sig; logic [31:0] val;} probe_t;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    write_t wq[$];
    probe_t pq[$];
    int     dq[$];
    logic [31:0] mel_mem [0:63];
    logic [31:0] cof_mem [0:63];
    mfcc_dct_if bus ();
    mfcc_dct dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        bus.mel_data_in <= mel_mem[bus.mel_mem_read_addr[5:0]];
        bus.dct_cof_in  <= cof_mem[bus.dct_cof_read_addr[5:0]];
    end
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask
    task automatic probe(input int c, input int sig, input logic [31:0] val);
        probe_t p;
        p.cyc = c;
        p.sig = sig;
        p.val = val;
        pq.push_back(p);
    endtask
    task automatic expect_frame(input int s, input int mm, input int kk, input logic [31:0] e0,
                                input logic [31:0] e1, output int d);
        int     per;
        write_t w;
        per = 6 * mm + 1;
        if (mm == 0 || kk == 0) begin
            d = s + 1;
            probe(d, 2, 0);
            dq.push_back(d);
            return;
        end
        d = s + kk * per + 1;
        probe(s + 1, 2, 1);
        for (int k = 0; k < kk; k++) begin
            for (int j = 0; j < mm; j++) begin
                probe(s + 1 + k * per + 6 * j, 0, k * mm + j);
                probe(s + 1 + k * per + 6 * j, 1, j);
            end
            w.cyc  = s + (k + 1) * per;
            w.addr = k;
            w.data = (k == 0) ? e0 : e1;
            wq.push_back(w);
        end
        probe(d, 2, 0);
        dq.push_back(d);
    endtask
    task automatic frame(input int mm, input int kk, input bit push, input logic [31:0] e0,
                         input logic [31:0] e1, output int s, output int d);
        @(negedge clk);
        s = cyc;
        d = 0;
        if (push) expect_frame(s, mm, kk, e0, e1, d);
        bus.mel_num   = 6'(mm);
        bus.cep_num   = 6'(kk);
        bus.dct_start = 1'b1;
        @(negedge clk);
        bus.dct_start = 1'b0;
    endtask
    task automatic settle(input int t);
        while (cyc < t) @(negedge clk);
    endtask
    task automatic check_idle_outputs(input string tag);
        check({tag, "_wen"}, {31'd0, bus.write_mfcc_en}, 0);
        check({tag, "_busy"}, {31'd0, bus.dct_busy}, 0);
        check({tag, "_done"}, {31'd0, bus.dct_done}, 0);
        check({tag, "_waddr"}, {20'd0, bus.mfcc_write_addr}, 0);
        check({tag, "_wdata"}, bus.mfcc_data_out, 0);
        check({tag, "_meladdr"}, {20'd0, bus.mel_mem_read_addr}, 0);
        check({tag, "_cofaddr"}, {20'd0, bus.dct_cof_read_addr}, 0);
    endtask
    task automatic load_t1();
        mel_mem[0] = 32'h3F800000;
        mel_mem[1] = 32'h40000000;
        cof_mem[0] = 32'h3F000000;
        cof_mem[1] = 32'h3E800000;
    endtask
    task automatic load_t2();
        for (int i = 0; i < 3; i++) mel_mem[i] = 32'h3F800000;
        for (int i = 0; i < 3; i++) cof_mem[i] = 32'h3F800000;
        for (int i = 3; i < 6; i++) cof_mem[i] = 32'h40000000;
    endtask
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.write_mfcc_en) begin
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write at cycle %0d: addr %h data %h", cyc,
                             bus.mfcc_write_addr, bus.mfcc_data_out);
                end else begin
                    write_t w;
                    w = wq.pop_front();
                    check("write_cycle", cyc, w.cyc);
                    check("write_addr", {20'd0, bus.mfcc_write_addr}, w.addr);
                    check("write_data", bus.mfcc_data_out, w.data);
                end
            end
            if (bus.dct_done) begin
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    check("done_cycle", cyc, dq.pop_front());
                end
            end
            while (pq.size() != 0 && pq[0].cyc <= cyc) begin
                probe_t p;
                p = pq.pop_front();
                if (p.cyc < cyc) check("probe_missed", cyc, p.cyc);
                else if (p.sig == 0) check("cof_addr", {20'd0, bus.dct_cof_read_addr}, p.val);
                else if (p.sig == 1) check("mel_addr", {20'd0, bus.mel_mem_read_addr}, p.val);
                else check("busy", {31'd0, bus.dct_busy}, p.val);
            end
        end
    end
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int s, d;
        rst_n         = 1'b0;
        bus.dct_start = 1'b0;
        bus.mel_num   = 6'd0;
        bus.cep_num   = 6'd0;
        for (int i = 0; i < 64; i++) begin
            mel_mem[i] = 32'd0;
            cof_mem[i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        load_t1();
        frame(2, 1, 1, 32'h3F800000, 32'h0, s, d);
        settle(d + 1);
        load_t2();
        frame(3, 2, 1, 32'h40400000, 32'h40C00000, s, d);
        settle(d + 1);
        frame(0, 2, 1, 32'h0, 32'h0, s, d);
        settle(d + 1);
        frame(2, 0, 1, 32'h0, 32'h0, s, d);
        settle(d + 1);
        // restart and band-count change while busy must leave the frame untouched
        frame(3, 2, 1, 32'h40400000, 32'h40C00000, s, d);
        repeat (3) @(negedge clk);
        bus.dct_start = 1'b1;
        bus.mel_num   = 6'd7;
        bus.cep_num   = 6'd1;
        @(negedge clk);
        bus.dct_start = 1'b0;
        settle(d + 1);
        frame(3, 2, 0, 32'h0, 32'h0, s, d);
        settle(s + 11);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        frame(3, 2, 1, 32'h40400000, 32'h40C00000, s, d);
        settle(d + 1);
        load_t1();
        frame(2, 1, 1, 32'h3F800000, 32'h0, s, d);
        settle(d);
        frame(2, 1, 1, 32'h3F800000, 32'h0, s, d);
        settle(d + 3);
        check("pending_expectations", wq.size() + pq.size() + dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mfcc_dct.md
Name: mfcc_dct

Overview:
- Cepstral stage directly downstream of the mel filterbank/log block.
- Reads the log-mel energies that stage wrote into mel memory (addresses 0..mel_num-1, fp32).
- Computes c[k] = sum over m of log_mel[m] * dct_cof[k*mel_num + m] for k = 0..cep_num-1 and writes each c[k] to MFCC memory.
- Arithmetic uses the team's clocked fp32 multiplier and adder (mul_fp_clk, add_fp_clk), sequenced by an internal FSM.

Parameters:
- DATA_WIDTH, 32, fp32 word width
- ADDR_WIDTH, 12, mel/MFCC memory address width
- COF_ADDR_WIDTH, 12, DCT coefficient ROM address width
- MUL_LAT, 2, cycles from mul_fp_clk enable to valid product; must match the instantiated unit
- ADD_LAT, 2, cycles from add_fp_clk enable to valid sum; must match the instantiated unit

Ports:
- clk, input, 1, clock
- rst_n, input, 1, reset, asynchronous, active-low
- dct_start, input, 1, single-cycle start pulse, sampled only in IDLE
- mel_num, input, 6, number of mel bands M; sampled at start
- cep_num, input, 6, number of cepstral outputs K; sampled at start
- mel_mem_read_addr, output, ADDR_WIDTH, log-mel read address
- mel_data_in, input, DATA_WIDTH, log-mel read data, valid 1 cycle after address
- dct_cof_read_addr, output, COF_ADDR_WIDTH, coefficient ROM address
- dct_cof_in, input, DATA_WIDTH, coefficient data, valid 1 cycle after address
- mfcc_write_addr, output, ADDR_WIDTH, MFCC memory write address (= k)
- mfcc_data_out, output, DATA_WIDTH, c[k]
- write_mfcc_en, output, 1, one-cycle write strobe
- dct_busy, output, 1, high from the cycle after start until done
- dct_done, output, 1, one-cycle pulse when the frame is complete

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE.
  - Accumulator 0.
  - Counters m, k and coefficient address 0.
- FSM states: IDLE, ADDR, MEM, MUL, ADD, WRITE, DONE.
- IDLE:
  - On dct_start=1, latch mel_num and cep_num, clear m, k, coefficient address and accumulator.
  - Go to ADDR, or go to DONE if either latched count is 0 (no writes occur).
- ADDR (1 cycle): drive mel_mem_read_addr = m and dct_cof_read_addr = coefficient address.
- MEM (1 cycle): memory data arrives.
- MUL (MUL_LAT cycles): mul enable high, with operands mel_data_in and dct_cof_in.
- ADD (ADD_LAT cycles):
  - Adder enable high, with operands product and accumulator.
  - On the last ADD cycle the accumulator loads the sum.
- Term sequencing:
  - Each term takes 2 + MUL_LAT + ADD_LAT cycles (6 at defaults); terms are not pipelined.
  - After ADD, if m < M-1: increment m and the coefficient address, go to ADDR.
  - Otherwise go to WRITE.
- Coefficient address:
  - Incremented by 1 per term, never reset between coefficients, so it equals k*M + m with no multiplier.
  - Wraps modulo 2^COF_ADDR_WIDTH.
- WRITE (1 cycle):
  - write_mfcc_en=1, mfcc_write_addr=k, mfcc_data_out=accumulator.
  - Then clear the accumulator and m.
  - If k < K-1: increment k, go to ADDR. Otherwise go to DONE.
- DONE (1 cycle): dct_done=1, dct_busy=0 next cycle, return to IDLE.
- dct_busy is 1 in all states except IDLE and DONE.
- Edge conditions:
  - dct_start while busy is ignored.
  - Latched M/K are unaffected by input changes mid-frame.
  - The first write occurs exactly M*(2+MUL_LAT+ADD_LAT)+1 cycles after the start cycle.
  - A frame takes K*(M*(2+MUL_LAT+ADD_LAT)+1)+2 cycles from start to the dct_done pulse inclusive.
  - mfcc_write_addr and mfcc_data_out hold their last values outside WRITE.
  - The fp units are not required to handle NaN/Inf specially; results pass through.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no partial write completes.

Test Plan:
- M=2, K=1, mel=[1.0 (0x3F800000), 2.0 (0x40000000)], cof=[0.5, 0.25] -> one write: addr 0, data 0x3F800000 at cycle 13 after start; dct_done at cycle 14.
- M=3, K=2, mel=[1,1,1], cof=[1,1,1, 2,2,2] -> writes c[0]=3.0 (0x40400000) and c[1]=6.0 (0x40C00000); coefficient addresses 0..5 issued in order.
- M=0, or K=0 with start -> no write_mfcc_en; dct_done one cycle after IDLE exit; dct_busy never asserted.
- dct_start pulsed again mid-frame, and mel_num changed mid-frame -> frame results and timing identical to an undisturbed run.
- rst_n low during the ADD state of the second term -> all outputs 0 immediately; a subsequent start produces correct results from c[0].
- Back-to-back frames: start asserted the cycle after dct_done -> second frame runs with the accumulator cleared; results identical to the first frame.
